// File: rtl/sort_pkg.sv
// Shared sorter types: FSM state encoding and per-job comparison mode.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        OUT
    } sort_state_t;

    typedef struct packed {
        logic descend;
        logic signed_cmp;
    } sort_mode_t;

endpackage

// File: rtl/sort_oets_if.sv
// Job/result channel of the odd-even transposition sorter (valid/ready on both sides).
interface sort_oets_if #(
    parameter int N     = 6,
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(N),
    parameter int PW    = $clog2(N + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data [N];
    logic             in_descend;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data [N];
    logic [IDXW-1:0]  out_idx [N];
    logic [PW-1:0]    out_phases;

    modport master (
        output in_valid, in_data, in_descend, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_phases
    );

    modport slave (
        input  in_valid, in_data, in_descend, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_phases
    );
endinterface

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange of one (key, tag) pair; equal keys never swap.
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic [WIDTH-1:0] key_lo,
    input  logic [WIDTH-1:0] key_hi,
    input  logic [IDXW-1:0]  tag_lo,
    input  logic [IDXW-1:0]  tag_hi,
    input  sort_mode_t       mode,
    output logic [WIDTH-1:0] new_key_lo,
    output logic [WIDTH-1:0] new_key_hi,
    output logic [IDXW-1:0]  new_tag_lo,
    output logic [IDXW-1:0]  new_tag_hi,
    output logic             swapped
);
    logic lo_gt_hi;
    logic hi_gt_lo;

    // Strict comparisons only, which is what keeps the sort stable.
    assign lo_gt_hi = mode.signed_cmp ? ($signed(key_lo) > $signed(key_hi)) : (key_lo > key_hi);
    assign hi_gt_lo = mode.signed_cmp ? ($signed(key_hi) > $signed(key_lo)) : (key_hi > key_lo);
    assign swapped  = mode.descend ? hi_gt_lo : lo_gt_hi;

    assign new_key_lo = swapped ? key_hi : key_lo;
    assign new_key_hi = swapped ? key_lo : key_hi;
    assign new_tag_lo = swapped ? tag_hi : tag_lo;
    assign new_tag_hi = swapped ? tag_lo : tag_hi;
endmodule

// File: rtl/sort_oets.sv
// Odd-even transposition sorter: one compare-exchange phase per clock, stable,
// with early exit after two consecutive swap-free phases.
//   state | meaning
//   IDLE  | waiting for a job, in_ready high
//   SORT  | one compare-exchange phase per cycle
//   OUT   | result presented until out_ready
module sort_oets
    import sort_pkg::*;
#(
    parameter int N     = 6,
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(N)
) (
    input  logic       clk,
    input  logic       rst_n,
    sort_oets_if.slave bus,
    output logic       busy
);
    localparam int PW = $clog2(N + 1);

    sort_state_t      state;
    sort_mode_t       mode;
    logic [WIDTH-1:0] key [N];
    logic [IDXW-1:0]  tag [N];
    logic [PW-1:0]    cnt;
    logic             quiet;

    logic [WIDTH-1:0] pr_key_lo [N-1];
    logic [WIDTH-1:0] pr_key_hi [N-1];
    logic [IDXW-1:0]  pr_tag_lo [N-1];
    logic [IDXW-1:0]  pr_tag_hi [N-1];
    logic             pr_sw     [N-1];

    logic [WIDTH-1:0] nxt_key [N];
    logic [IDXW-1:0]  nxt_tag [N];
    logic             any_sw;
    logic [PW-1:0]    cnt_nxt;
    logic             done;

    // One comparator per adjacent pair; pair i belongs to the parity of i.
    for (genvar i = 0; i < N - 1; i++) begin : g_pair
        sort_cmp_swap #(.WIDTH(WIDTH), .IDXW(IDXW)) u_cmp (
            .key_lo     (key[i]),
            .key_hi     (key[i+1]),
            .tag_lo     (tag[i]),
            .tag_hi     (tag[i+1]),
            .mode       (mode),
            .new_key_lo (pr_key_lo[i]),
            .new_key_hi (pr_key_hi[i]),
            .new_tag_lo (pr_tag_lo[i]),
            .new_tag_hi (pr_tag_hi[i]),
            .swapped    (pr_sw[i])
        );
    end

    always_comb begin
        nxt_key = key;
        nxt_tag = tag;
        any_sw  = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if ((i % 2 == 1) == cnt[0]) begin
                nxt_key[i]   = pr_key_lo[i];
                nxt_key[i+1] = pr_key_hi[i];
                nxt_tag[i]   = pr_tag_lo[i];
                nxt_tag[i+1] = pr_tag_hi[i];
                any_sw       = any_sw | pr_sw[i];
            end
        end
    end

    assign cnt_nxt = cnt + PW'(1);
    // quiet is cleared on accept, so the early exit needs at least two phases.
    assign done    = (cnt_nxt == PW'(N)) || (quiet && !any_sw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mode  <= '0;
            cnt   <= '0;
            quiet <= 1'b0;
            for (int i = 0; i < N; i++) begin
                key[i] <= '0;
                tag[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        key   <= bus.in_data;
                        for (int i = 0; i < N; i++) tag[i] <= IDXW'(i);
                        mode  <= '{descend: bus.in_descend, signed_cmp: bus.in_signed};
                        cnt   <= '0;
                        quiet <= 1'b0;
                        state <= SORT;
                    end
                end
                SORT: begin
                    key   <= nxt_key;
                    tag   <= nxt_tag;
                    cnt   <= cnt_nxt;
                    quiet <= !any_sw;
                    if (done) state <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == OUT);
    assign busy           = (state == SORT);
    assign bus.out_data   = key;
    assign bus.out_idx    = tag;
    assign bus.out_phases = cnt;
endmodule

// File: tb/tb_sort_oets.sv
// Directed bench for sort_oets (N=6, WIDTH=8) with hand-computed expectations.
module tb_sort_oets;
    import sort_pkg::*;

    localparam int N     = 6;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    logic busy;
    int   ntot;
    int   npass;

    sort_oets_if #(.N(N), .WIDTH(WIDTH)) bus ();

    sort_oets #(.N(N), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [47:0] got_data();
        logic [47:0] v;
        for (int i = 0; i < N; i++) v[47-8*i -: 8] = bus.out_data[i];
        return v;
    endfunction

    function automatic logic [17:0] got_idx();
        logic [17:0] v;
        for (int i = 0; i < N; i++) v[17-3*i -: 3] = bus.out_idx[i];
        return v;
    endfunction

    task automatic set_inputs(input logic [47:0] keys, input logic desc, input logic sgn);
        for (int i = 0; i < N; i++) bus.in_data[i] = keys[47-8*i -: 8];
        bus.in_descend = desc;
        bus.in_signed  = sgn;
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic drive_job(input string tag, input logic [47:0] keys, input logic desc, input logic sgn);
        set_inputs(keys, desc, sgn);
        bus.in_valid = 1'b1;
        check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        set_inputs(48'hA5A5A5A5A5A5, ~desc, ~sgn);
        check({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic wait_out(input string tag, input int exp_p);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_p));
    endtask

    task automatic check_res(input string tag, input logic [47:0] ed, input logic [17:0] ei, input int ep);
        check({tag, "_data"},   64'(got_data()), 64'(ed));
        check({tag, "_idx"},    64'(got_idx()), 64'(ei));
        check({tag, "_phases"}, 64'(bus.out_phases), 64'(ep));
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_drain_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_drain_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic full_job(input string tag, input logic [47:0] keys, input logic desc, input logic sgn,
                            input logic [47:0] ed, input logic [17:0] ei, input int ep);
        drive_job(tag, keys, desc, sgn);
        wait_out(tag, ep);
        check_res(tag, ed, ei, ep);
        drain(tag);
    endtask

    initial begin
        clk            = 1'b0;
        rst_n          = 1'b0;
        ntot           = 0;
        npass          = 0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        set_inputs(48'h0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check_res("rst", 48'h0, 18'h0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_out_ready_valid", 64'(bus.out_valid), 64'd0);
        check("idle_out_ready_ready", 64'(bus.in_ready), 64'd1);

        full_job("asc_u", 48'h050309010900, 1'b0, 1'b0, 48'h000103050909,
                 {3'd5, 3'd3, 3'd1, 3'd0, 3'd2, 3'd4}, 6);
        full_job("sorted", 48'h010203040506, 1'b0, 1'b0, 48'h010203040506,
                 {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5}, 2);
        full_job("desc_s", 48'h807FFF0001FE, 1'b1, 1'b1, 48'h7F0100FFFE80,
                 {3'd1, 3'd4, 3'd3, 3'd2, 3'd5, 3'd0}, 6);
        full_job("asc_u2", 48'h807FFF0001FE, 1'b0, 1'b0, 48'h00017F80FEFF,
                 {3'd3, 3'd4, 3'd1, 3'd0, 3'd5, 3'd2}, 6);
        full_job("reversed", 48'h060504030201, 1'b0, 1'b0, 48'h010203040506,
                 {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 6);
        full_job("early3", 48'h020103040506, 1'b0, 1'b0, 48'h010203040506,
                 {3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5}, 3);
        full_job("equal_desc", 48'h030303030303, 1'b1, 1'b0, 48'h030303030303,
                 {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5}, 2);

        // Backpressure with a second job offered while the first is held.
        drive_job("bp", 48'h010203040506, 1'b0, 1'b0);
        wait_out("bp", 2);
        set_inputs(48'h020103040506, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_ready", 64'(bus.in_ready), 64'd0);
            check("bp_hold_data",  64'(got_data()), 64'h010203040506);
        end
        check_res("bp_hold", 48'h010203040506, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5}, 2);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_after_hs_valid", 64'(bus.out_valid), 64'd0);
        check("bp_after_hs_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        set_inputs(48'hFFFFFFFFFFFF, 1'b1, 1'b1);
        check("bp2_busy", 64'(busy), 64'd1);
        wait_out("bp2", 3);
        check_res("bp2", 48'h010203040506, {3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5}, 3);
        drain("bp2");

        // Reset in the middle of a sort discards the job.
        drive_job("mid_rst", 48'h060504030201, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready",  64'(bus.in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_busy",      64'(busy), 64'd0);
        check_res("mid_rst", 48'h0, 18'h0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        full_job("post_rst", 48'h050309010900, 1'b0, 1'b0, 48'h000103050909,
                 {3'd5, 3'd3, 3'd1, 3'd0, 3'd2, 3'd4}, 6);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
